// File: rtl/timing_pkg.sv
// timing_pkg: phase numbering, buffer path codes and D0_D3 source selects for the machine cycle.
package timing_pkg;
    localparam logic [2:0] A1 = 3'd0;
    localparam logic [2:0] A2 = 3'd1;
    localparam logic [2:0] A3 = 3'd2;
    localparam logic [2:0] M1 = 3'd3;
    localparam logic [2:0] M2 = 3'd4;
    localparam logic [2:0] X1 = 3'd5;
    localparam logic [2:0] X2 = 3'd6;
    localparam logic [2:0] X3 = 3'd7;
    localparam logic [1:0] PATH_LOAD    = 2'b00;
    localparam logic [1:0] PATH_DRIVE   = 2'b01;
    localparam logic [1:0] PATH_IDLE    = 2'b10;
    localparam logic [1:0] PATH_CAPTURE = 2'b11;
    localparam logic [1:0] DSEL_PCL = 2'd0;
    localparam logic [1:0] DSEL_PCM = 2'd1;
    localparam logic [1:0] DSEL_PCH = 2'd2;
    localparam logic [1:0] DSEL_ACC = 2'd3;
endpackage

// File: rtl/phase_counter.sv
// phase_counter: free-running phase/sub-step counter; exposes next state so outputs can be registered in step.
module phase_counter
    import timing_pkg::*;
(
    input  logic       clk_2,
    input  logic       rst_n,
    output logic [2:0] phase,
    output logic       sub,
    output logic [2:0] phase_nx,
    output logic       sub_nx,
    output logic       last
);
    // X3 + 1 wraps to A1 through the 3-bit overflow
    assign phase_nx = sub ? phase + 3'd1 : phase;
    assign sub_nx   = ~sub;
    assign last     = (phase == X3) && sub;

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            phase <= A1;
            sub   <= 1'b0;
        end else begin
            phase <= phase_nx;
            sub   <= sub_nx;
        end
    end
endmodule

// File: rtl/machine_cycle_timing.sv
// machine_cycle_timing: 8-phase machine-cycle sequencer for the 4-bit data bus buffer.
// Every output is decoded from the next state and registered, so it lines up with phase/sub.
module machine_cycle_timing
    import timing_pkg::*;
(
    input  logic       clk_2,
    input  logic       rst_n,
    input  logic       io_out,
    input  logic       io_in,
    input  logic       two_word,
    output logic       data_bus_buffer_enable,
    output logic [1:0] data_bus_buffer_path,
    output logic [1:0] d_sel,
    output logic       opr_load,
    output logic       opa_load,
    output logic       arg_load,
    output logic       pc_inc,
    output logic       sync,
    output logic [2:0] phase,
    output logic       second_word
);
    logic       sub, sub_nx, last;
    logic [2:0] phase_nx;
    logic       io_out_q, io_in_q;
    logic       sw_nx, io_out_nx, io_in_nx, samp;
    logic       en_nx;
    logic [1:0] path_nx, dsel_nx;

    phase_counter u_phase_counter (
        .clk_2    (clk_2),
        .rst_n    (rst_n),
        .phase    (phase),
        .sub      (sub),
        .phase_nx (phase_nx),
        .sub_nx   (sub_nx),
        .last     (last)
    );

    // second word never chains into a third
    assign sw_nx     = last ? (two_word & ~second_word) : second_word;
    assign samp      = (phase == X1) && sub;
    assign io_out_nx = samp ? io_out : io_out_q;
    assign io_in_nx  = samp ? io_in : io_in_q;

    always_comb begin
        en_nx   = 1'b1;
        path_nx = PATH_IDLE;
        dsel_nx = DSEL_PCL;
        if (phase_nx <= A3) begin
            en_nx   = 1'b0;
            dsel_nx = phase_nx[1:0];
            path_nx = sub_nx ? PATH_DRIVE : PATH_LOAD;
        end else if (phase_nx == M1 || phase_nx == M2) begin
            en_nx   = 1'b0;
            path_nx = sub_nx ? PATH_CAPTURE : PATH_IDLE;
        end else if (phase_nx == X2 && io_out_nx) begin
            en_nx   = 1'b0;
            dsel_nx = DSEL_ACC;
            path_nx = sub_nx ? PATH_DRIVE : PATH_LOAD;
        end else if (phase_nx == X2 && io_in_nx) begin
            en_nx   = 1'b0;
            path_nx = sub_nx ? PATH_CAPTURE : PATH_IDLE;
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            second_word            <= 1'b0;
            io_out_q               <= 1'b0;
            io_in_q                <= 1'b0;
            data_bus_buffer_enable <= 1'b1;
            data_bus_buffer_path   <= PATH_IDLE;
            d_sel                  <= DSEL_PCL;
            opr_load               <= 1'b0;
            opa_load               <= 1'b0;
            arg_load               <= 1'b0;
            pc_inc                 <= 1'b0;
            sync                   <= 1'b0;
        end else begin
            second_word            <= sw_nx;
            io_out_q               <= io_out_nx;
            io_in_q                <= io_in_nx;
            data_bus_buffer_enable <= en_nx;
            data_bus_buffer_path   <= path_nx;
            d_sel                  <= dsel_nx;
            opr_load               <= !sub_nx && phase_nx == M2 && !sw_nx;
            opa_load               <= !sub_nx && phase_nx == X1 && !sw_nx;
            arg_load               <= !sub_nx && (phase_nx == M2 || phase_nx == X1) && sw_nx;
            pc_inc                 <= sub_nx && phase_nx == A3;
            sync                   <= phase_nx == X3;
        end
    end
endmodule

// File: tb/tb_machine_cycle_timing.sv
// tb_machine_cycle_timing: clock-index reference model compared every cycle, plus literal checks of the timing table.
module tb_machine_cycle_timing;
    logic       clk_2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       io_out = 1'b0, io_in = 1'b0, two_word = 1'b0;
    logic       data_bus_buffer_enable, opr_load, opa_load, arg_load, pc_inc, sync, second_word;
    logic [1:0] data_bus_buffer_path, d_sel;
    logic [2:0] phase;

    int passed = 0, total = 0;

    typedef struct packed {
        logic       en;
        logic [1:0] path;
        logic       opr, opa, arg, pc, sync;
        logic [2:0] ph;
        logic       sw;
    } exp_t;

    machine_cycle_timing dut (
        .clk_2                  (clk_2),
        .rst_n                  (rst_n),
        .io_out                 (io_out),
        .io_in                  (io_in),
        .two_word               (two_word),
        .data_bus_buffer_enable (data_bus_buffer_enable),
        .data_bus_buffer_path   (data_bus_buffer_path),
        .d_sel                  (d_sel),
        .opr_load               (opr_load),
        .opa_load               (opa_load),
        .arg_load               (arg_load),
        .pc_inc                 (pc_inc),
        .sync                   (sync),
        .phase                  (phase),
        .second_word            (second_word)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // model: k is the clock index inside the cycle (0..15), phase = k/2, sub = k%2
    int mk = 0;
    bit msw = 0, mio = 0, mii = 0, mrst = 1, cmp_en = 0;

    always @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            mk = 0; msw = 0; mio = 0; mii = 0; mrst = 1;
        end else begin
            if (mk == 11) begin mio = io_out; mii = io_in; end
            if (mk == 15) msw = two_word && !msw;
            mk = (mk + 1) % 16;
            mrst = 0;
        end
    end

    function automatic exp_t model_out(input int k, input bit sw, input bit oo, input bit ii, input bit rst);
        exp_t e;
        int ph;
        bit sb, x2;
        ph = k / 2;
        sb = (k % 2) == 1;
        x2 = ph == 6;
        e.en   = rst ? 1'b1 : !(k < 10 || (x2 && (oo || ii)));
        e.path = rst ? 2'b10 : (k < 6 || (x2 && oo)) ? {1'b0, sb} : (k < 10 || (x2 && ii)) ? {1'b1, sb} : 2'b10;
        e.opr  = !rst && k == 8 && !sw;
        e.opa  = !rst && k == 10 && !sw;
        e.arg  = !rst && (k == 8 || k == 10) && sw;
        e.pc   = !rst && k == 5;
        e.sync = !rst && k >= 14;
        e.ph   = rst ? 3'd0 : 3'(ph);
        e.sw   = sw;
        return e;
    endfunction

    exp_t ec;
    always @(negedge clk_2) if (cmp_en) begin
        ec = model_out(mk, msw, mio, mii, mrst);
        chk("enable", 32'(data_bus_buffer_enable), 32'(ec.en));
        chk("path", 32'(data_bus_buffer_path), 32'(ec.path));
        chk("opr_load", 32'(opr_load), 32'(ec.opr));
        chk("opa_load", 32'(opa_load), 32'(ec.opa));
        chk("arg_load", 32'(arg_load), 32'(ec.arg));
        chk("pc_inc", 32'(pc_inc), 32'(ec.pc));
        chk("sync", 32'(sync), 32'(ec.sync));
        chk("phase", 32'(phase), 32'(ec.ph));
        chk("second_word", 32'(second_word), 32'(ec.sw));
        if (!mrst && (mk < 6 || (mk / 2 == 6 && mio)))
            chk("d_sel", 32'(d_sel), (mk < 6) ? 32'(mk / 2) : 32'd3);
    end

    task automatic wait_idx(input int t);
        int n = 0;
        do begin
            @(posedge clk_2); #2;
            n++;
        end while (mk != t && n < 40);
        if (mk != t) chk("wait_idx_timeout", 32'(mk), 32'(t));
    endtask

    logic [15:0] ev, pcv, oprv, opav, syncv;
    logic [19:0] pv;
    logic [11:0] dv;

    initial begin
        repeat (3) @(posedge clk_2);
        cmp_en = 1;
        #1;
        chk("rst_enable", 32'(data_bus_buffer_enable), 32'd1);
        chk("rst_path", 32'(data_bus_buffer_path), 32'd2);
        chk("rst_dsel", 32'(d_sel), 32'd0);
        chk("rst_strobes", 32'({opr_load, opa_load, arg_load, pc_inc, sync}), 32'd0);
        #1;
        rst_n = 1;
        // free run with io/two_word low: capture one full cycle by clock index
        wait_idx(0);
        ev = '0; pcv = '0; oprv = '0; opav = '0; syncv = '0; pv = '0; dv = '0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk_2);
            ev[j] = data_bus_buffer_enable;
            pcv[j] = pc_inc;
            oprv[j] = opr_load;
            opav[j] = opa_load;
            syncv[j] = sync;
            if (j < 10) pv[19-2*j -: 2] = data_bus_buffer_path;
            if (j < 6) dv[11-2*j -: 2] = d_sel;
            @(posedge clk_2); #2;
        end
        chk("lit_enable_vec", 32'(ev), 32'h0000_FC00);
        chk("lit_path_seq", 32'(pv), 32'b00_01_00_01_00_01_10_11_10_11);
        chk("lit_dsel_seq", 32'(dv), 32'b00_00_01_01_10_10);
        chk("lit_pc_inc_vec", 32'(pcv), 32'h0000_0020);
        chk("lit_opr_vec", 32'(oprv), 32'h0000_0100);
        chk("lit_opa_vec", 32'(opav), 32'h0000_0400);
        chk("lit_sync_vec", 32'(syncv), 32'h0000_C000);
        chk("lit_wrap_phase", 32'(phase), 32'd0);
        chk("lit_wrap_path", 32'(data_bus_buffer_path), 32'd0);
        // io_out in X1 -> X2 drives the bus from ACC
        wait_idx(10); io_out = 1;
        wait_idx(12); io_out = 0;
        @(negedge clk_2);
        chk("x2out_enable", 32'(data_bus_buffer_enable), 32'd0);
        chk("x2out_dsel", 32'(d_sel), 32'd3);
        chk("x2out_path0", 32'(data_bus_buffer_path), 32'd0);
        @(posedge clk_2); #2;
        @(negedge clk_2);
        chk("x2out_path1", 32'(data_bus_buffer_path), 32'd1);
        // io_in sampled in X1, dropped in X2 -> capture still happens
        wait_idx(10); io_in = 1;
        wait_idx(12); io_in = 0;
        @(negedge clk_2);
        chk("x2in_path0", 32'(data_bus_buffer_path), 32'd2);
        chk("x2in_enable", 32'(data_bus_buffer_enable), 32'd0);
        @(posedge clk_2); #2;
        @(negedge clk_2);
        chk("x2in_path1", 32'(data_bus_buffer_path), 32'd3);
        // both set -> io_out wins
        wait_idx(10); io_in = 1; io_out = 1;
        wait_idx(12); io_in = 0; io_out = 0;
        @(negedge clk_2);
        chk("x2both_path0", 32'(data_bus_buffer_path), 32'd0);
        chk("x2both_dsel", 32'(d_sel), 32'd3);
        // two_word: one second-word cycle, then no chaining while held
        wait_idx(14); two_word = 1;
        wait_idx(0);
        chk("tw_second_word", 32'(second_word), 32'd1);
        wait_idx(8);
        @(negedge clk_2);
        chk("tw_arg_m2", 32'(arg_load), 32'd1);
        chk("tw_no_opr", 32'(opr_load), 32'd0);
        wait_idx(10);
        @(negedge clk_2);
        chk("tw_arg_x1", 32'(arg_load), 32'd1);
        chk("tw_no_opa", 32'(opa_load), 32'd0);
        wait_idx(0);
        chk("tw_no_chain", 32'(second_word), 32'd0);
        two_word = 0;
        // reset in M1 sub1: immediate reset values, no opr_load afterwards
        wait_idx(7);
        rst_n = 0;
        #1;
        chk("midrst_enable", 32'(data_bus_buffer_enable), 32'd1);
        chk("midrst_path", 32'(data_bus_buffer_path), 32'd2);
        chk("midrst_phase", 32'(phase), 32'd0);
        repeat (3) begin
            @(negedge clk_2);
            chk("midrst_no_opr", 32'(opr_load), 32'd0);
        end
        @(posedge clk_2); #2;
        rst_n = 1;
        // randomized run with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_2); #2;
            io_out = $urandom_range(0, 3) == 0;
            io_in = $urandom_range(0, 2) == 0;
            two_word = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 0;
                @(posedge clk_2); #2;
                rst_n = 1;
            end
        end
        @(negedge clk_2);
        cmp_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
